// File: rtl/cv32e40p_ft_block_monitor.sv
// ---------------------------------------------------------------------------
// cv32e40p_ft_block_monitor
//
// Sits at the consumer end of a TMR voter's error interface. It counts
// correctable disagreements for each of the three copies, moves each copy
// through HEALTHY -> SUSPECT -> BROKEN, and feeds broken_block_o back to the
// voter so that a persistently faulty copy is outvoted. Conditions the voter
// cannot repair raise a sticky fatal flag for the fault-tolerance controller.
//
// Optional feature: define CV32E40P_FT_MON_LEAK_EN to enable counter leak.
// Every LEAK_PERIOD cycles, each SUSPECT copy decrements by one, and it
// returns to HEALTHY when it reaches zero.
//
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   valid_i         voter outputs are meaningful this cycle
//   block_err_i     per-copy disagreement flags
//   err_detected_i  voter saw a mismatch
//   err_corrected_i voter produced a correct majority
//   clear_i         per-copy clear (repair / scrub done)
//   fatal_clr_i     clears the sticky fatal flag
//   broken_block_o  registered broken mask, to the voter
//   err_cnt_o       per-copy error counters
//   state_o         per-copy state (0 HEALTHY, 1 SUSPECT, 2 BROKEN)
//   broken_evt_o    one-cycle pulse when a copy enters BROKEN
//   fatal_o         sticky unrecoverable-condition flag
// ---------------------------------------------------------------------------
module cv32e40p_ft_block_monitor #(
    parameter int ERR_THRESH  = 4,
    parameter int CNT_W       = 8,
    parameter int LEAK_PERIOD = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    input  logic [2:0]                block_err_i,
    input  logic                      err_detected_i,
    input  logic                      err_corrected_i,
    input  logic [2:0]                clear_i,
    input  logic                      fatal_clr_i,
    output logic [2:0]                broken_block_o,
    output logic [2:0][CNT_W-1:0]     err_cnt_o,
    output logic [2:0][1:0]           state_o,
    output logic                      broken_evt_o,
    output logic                      fatal_o
);

    typedef enum logic [1:0] {
        ST_HEALTHY = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_BROKEN  = 2'd2
    } st_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ERR_THRESH);

    st_e              r_state   [0:2];
    st_e              w_state_nxt [0:2];
    logic [CNT_W-1:0] r_cnt     [0:2];
    logic [CNT_W-1:0] w_cnt_nxt [0:2];
    logic [CNT_W-1:0] w_cnt_inc;
    logic [2:0]       r_bb, w_bb_nxt;
    logic             r_evt, w_evt_nxt;
    logic             r_fatal, w_fatal_nxt;
    logic [2:0]       w_brk_now, w_brk_kept, w_live_err, w_inc, w_other;
    logic             w_one_hot, w_multi, w_uncorr, w_thr_fatal;
    logic             w_tick;

`ifdef CV32E40P_FT_MON_LEAK_EN
    localparam int TICK_W = $clog2(LEAK_PERIOD);
    logic [TICK_W-1:0] r_tick;

    // Free-running; the leak fires on the cycle the counter wraps.
    always_ff @(posedge clk) begin
        if (rst) r_tick <= '0;
        else     r_tick <= r_tick + 1'b1;
    end
    assign w_tick = (r_tick == {TICK_W{1'b1}});
`else
    logic w_unused_leak;
    assign w_unused_leak = (LEAK_PERIOD != 0);
    assign w_tick        = 1'b0;
`endif

    always_comb begin
        w_brk_now = '0;
        for (int k = 0; k < 3; k++) w_brk_now[k] = (r_state[k] == ST_BROKEN);
        w_live_err = block_err_i & ~w_brk_now;
        w_one_hot  = (block_err_i != 3'b000) && ((block_err_i & (block_err_i - 3'd1)) == 3'b000);
        // Two or more disagreeing copies among those still voting.
        w_multi    = ((w_live_err & (w_live_err - 3'd1)) != 3'b000);
        w_uncorr   = valid_i && (w_multi || (err_detected_i && !err_corrected_i));
        // Broken mask after this cycle's clears, so a clear frees the slot.
        w_brk_kept = w_brk_now & ~clear_i;

        w_thr_fatal = 1'b0;
        w_evt_nxt   = 1'b0;
        w_bb_nxt    = '0;
        w_inc       = '0;
        w_other     = '0;
        w_cnt_inc   = '0;
        for (int k = 0; k < 3; k++) begin
            w_cnt_nxt[k]   = r_cnt[k];
            w_state_nxt[k] = r_state[k];
            w_inc[k]   = valid_i && w_one_hot && err_corrected_i &&
                         block_err_i[k] && !w_brk_now[k];
            w_cnt_inc  = (r_cnt[k] == CNT_MAX) ? CNT_MAX : r_cnt[k] + 1'b1;
            w_other    = w_brk_kept;
            w_other[k] = 1'b0;
            if (clear_i[k]) begin
                w_cnt_nxt[k]   = '0;
                w_state_nxt[k] = ST_HEALTHY;
            end else if (w_inc[k]) begin
                w_cnt_nxt[k] = w_cnt_inc;
                if (w_cnt_inc >= THRESH) begin
                    if (w_other != 3'b000) begin
                        // Only one copy may be excluded; a second failing copy
                        // leaves the group without a trusted majority.
                        w_state_nxt[k] = ST_SUSPECT;
                        w_thr_fatal    = 1'b1;
                    end else begin
                        w_state_nxt[k] = ST_BROKEN;
                        w_evt_nxt      = 1'b1;
                    end
                end else begin
                    w_state_nxt[k] = ST_SUSPECT;
                end
            end else if (w_tick && (r_state[k] == ST_SUSPECT) && (r_cnt[k] != '0)) begin
                w_cnt_nxt[k] = r_cnt[k] - 1'b1;
                if (r_cnt[k] == CNT_W'(1)) w_state_nxt[k] = ST_HEALTHY;
            end
            w_bb_nxt[k] = (w_state_nxt[k] == ST_BROKEN);
        end
        w_fatal_nxt = (r_fatal && !fatal_clr_i) || w_uncorr || w_thr_fatal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                r_cnt[k]   <= '0;
                r_state[k] <= ST_HEALTHY;
            end
            r_bb    <= '0;
            r_evt   <= 1'b0;
            r_fatal <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                r_cnt[k]   <= w_cnt_nxt[k];
                r_state[k] <= w_state_nxt[k];
            end
            r_bb    <= w_bb_nxt;
            r_evt   <= w_evt_nxt;
            r_fatal <= w_fatal_nxt;
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            err_cnt_o[k] = r_cnt[k];
            state_o[k]   = r_state[k];
        end
    end

    assign broken_block_o = r_bb;
    assign broken_evt_o   = r_evt;
    assign fatal_o        = r_fatal;

endmodule

// File: tb/tb_cv32e40p_ft_block_monitor.sv
module tb_cv32e40p_ft_block_monitor;

    localparam int CW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_i, err_detected_i, err_corrected_i, fatal_clr_i;
    logic [2:0]        block_err_i, clear_i;
    logic [2:0]        broken_block_o;
    logic [2:0][CW-1:0] err_cnt_o;
    logic [2:0][1:0]   state_o;
    logic              broken_evt_o, fatal_o;

    int total = 0;
    int bad   = 0;

    cv32e40p_ft_block_monitor #(.ERR_THRESH(4), .CNT_W(CW), .LEAK_PERIOD(4)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .block_err_i(block_err_i),
        .err_detected_i(err_detected_i), .err_corrected_i(err_corrected_i),
        .clear_i(clear_i), .fatal_clr_i(fatal_clr_i),
        .broken_block_o(broken_block_o), .err_cnt_o(err_cnt_o), .state_o(state_o),
        .broken_evt_o(broken_evt_o), .fatal_o(fatal_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [2:0]  be;
        logic        det, cor;
        logic [2:0]  clr;
        logic        fcl;
        logic [23:0] cnt;   // {cnt2, cnt1, cnt0}
        logic [5:0]  st;    // {st2, st1, st0}
        logic [2:0]  bb;
        logic        evt, fat;
    } vec_t;

    function automatic vec_t mk(logic v, logic [2:0] be, logic det, logic cor,
                                logic [2:0] clr, logic fcl,
                                int c0, int c1, int c2, int s0, int s1, int s2,
                                logic [2:0] bb, logic evt, logic fat);
        vec_t r;
        r.v = v; r.be = be; r.det = det; r.cor = cor; r.clr = clr; r.fcl = fcl;
        r.cnt = {8'(c2), 8'(c1), 8'(c0)};
        r.st  = {2'(s2), 2'(s1), 2'(s0)};
        r.bb = bb; r.evt = evt; r.fat = fat;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [2:0] be, logic det, logic cor,
                         logic [2:0] clr, logic fcl);
        valid_i = v; block_err_i = be; err_detected_i = det;
        err_corrected_i = cor; clear_i = clr; fatal_clr_i = fcl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(string tag, logic [23:0] cnt, logic [5:0] st,
                           logic [2:0] bb, logic evt, logic fat);
        chk({tag, ".cnt"},   32'(err_cnt_o),      32'(cnt));
        chk({tag, ".state"}, 32'(state_o),        32'(st));
        chk({tag, ".bb"},    32'(broken_block_o), 32'(bb));
        chk({tag, ".evt"},   32'(broken_evt_o),   32'(evt));
        chk({tag, ".fatal"}, 32'(fatal_o),        32'(fat));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                  3'($urandom), 1'($urandom));
            step();
        end
        chk_all("reset", 24'd0, 6'd0, 3'b000, 1'b0, 1'b0);
        rst = 1'b0;
        drive(0, 3'b000, 0, 0, 3'b000, 0);
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1;
        drive(0, 3'b000, 0, 0, 3'b000, 0);
        do_reset();

`ifndef CV32E40P_FT_MON_LEAK_EN
        //               v  be     d c  clr    f  c0 c1 c2 s0 s1 s2 bb     e f
        tbl.push_back(mk(0, 3'b010,1,1, 3'b000,0, 0, 0, 0, 0, 0, 0, 3'b000,0,0));
        tbl.push_back(mk(1, 3'b010,1,1, 3'b000,0, 0, 1, 0, 0, 1, 0, 3'b000,0,0));
        tbl.push_back(mk(1, 3'b010,1,1, 3'b000,0, 0, 2, 0, 0, 1, 0, 3'b000,0,0));
        tbl.push_back(mk(1, 3'b010,1,1, 3'b000,0, 0, 3, 0, 0, 1, 0, 3'b000,0,0));
        tbl.push_back(mk(1, 3'b010,1,1, 3'b000,0, 0, 4, 0, 0, 2, 0, 3'b010,1,0));
        tbl.push_back(mk(1, 3'b010,1,1, 3'b000,0, 0, 4, 0, 0, 2, 0, 3'b010,0,0));
        tbl.push_back(mk(1, 3'b001,1,1, 3'b000,0, 1, 4, 0, 1, 2, 0, 3'b010,0,0));
        tbl.push_back(mk(1, 3'b001,1,1, 3'b000,0, 2, 4, 0, 1, 2, 0, 3'b010,0,0));
        tbl.push_back(mk(1, 3'b001,1,1, 3'b000,0, 3, 4, 0, 1, 2, 0, 3'b010,0,0));
        tbl.push_back(mk(1, 3'b001,1,1, 3'b000,0, 4, 4, 0, 1, 2, 0, 3'b010,0,1));
        tbl.push_back(mk(0, 3'b000,0,0, 3'b000,0, 4, 4, 0, 1, 2, 0, 3'b010,0,1));
        tbl.push_back(mk(0, 3'b000,0,0, 3'b000,1, 4, 4, 0, 1, 2, 0, 3'b010,0,0));
        // only one live copy disagrees: neither counted nor fatal
        tbl.push_back(mk(1, 3'b011,1,1, 3'b000,0, 4, 4, 0, 1, 2, 0, 3'b010,0,0));
        tbl.push_back(mk(1, 3'b101,1,1, 3'b000,0, 4, 4, 0, 1, 2, 0, 3'b010,0,1));
        tbl.push_back(mk(1, 3'b000,1,0, 3'b000,1, 4, 4, 0, 1, 2, 0, 3'b010,0,1));
        tbl.push_back(mk(0, 3'b000,0,0, 3'b000,1, 4, 4, 0, 1, 2, 0, 3'b010,0,0));
        tbl.push_back(mk(0, 3'b000,0,0, 3'b010,0, 4, 0, 0, 1, 0, 0, 3'b000,0,0));
        tbl.push_back(mk(1, 3'b001,1,1, 3'b000,0, 5, 0, 0, 2, 0, 0, 3'b001,1,0));
        tbl.push_back(mk(1, 3'b100,1,1, 3'b000,0, 5, 0, 1, 2, 0, 1, 3'b001,0,0));
        tbl.push_back(mk(1, 3'b100,1,1, 3'b000,0, 5, 0, 2, 2, 0, 1, 3'b001,0,0));
        tbl.push_back(mk(1, 3'b100,1,1, 3'b000,0, 5, 0, 3, 2, 0, 1, 3'b001,0,0));
        // clear of broken copy 0 and threshold hit on copy 2 together
        tbl.push_back(mk(1, 3'b100,1,1, 3'b001,0, 0, 0, 4, 0, 0, 2, 3'b100,1,0));
        tbl.push_back(mk(1, 3'b001,1,1, 3'b000,0, 1, 0, 4, 1, 0, 2, 3'b100,0,0));
        tbl.push_back(mk(1, 3'b001,1,1, 3'b000,0, 2, 0, 4, 1, 0, 2, 3'b100,0,0));
        tbl.push_back(mk(1, 3'b001,1,1, 3'b001,0, 0, 0, 4, 0, 0, 2, 3'b100,0,0));
        tbl.push_back(mk(1, 3'b000,1,0, 3'b000,0, 0, 0, 4, 0, 0, 2, 3'b100,0,1));
        tbl.push_back(mk(0, 3'b000,0,0, 3'b000,1, 0, 0, 4, 0, 0, 2, 3'b100,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].be, tbl[i].det, tbl[i].cor, tbl[i].clr, tbl[i].fcl);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].st, tbl[i].bb,
                    tbl[i].evt, tbl[i].fat);
        end

        // Saturation: copy 2 is BROKEN, so copy 0 climbs past threshold.
        drive(1, 3'b001, 1, 1, 3'b000, 0);
        for (int i = 0; i < 260; i++) step();
        chk_all("sat", {8'd4, 8'd0, 8'd255}, {2'd2, 2'd0, 2'd1}, 3'b100, 1'b0, 1'b1);

        // Reset while an error is being presented.
        rst = 1'b1;
        drive(1, 3'b010, 1, 1, 3'b000, 0);
        step();
        chk_all("rst_mid", 24'd0, 6'd0, 3'b000, 1'b0, 1'b0);
        rst = 1'b0;
        drive(0, 3'b000, 0, 0, 3'b000, 0);
`endif

        // Leak: restart so the tick counter phase is known (wrap on 4th edge).
        do_reset();
        drive(1, 3'b100, 1, 1, 3'b000, 0);
        step(); step();
        chk("leak.cnt_start", 32'(err_cnt_o[2]), 32'd2);
        drive(0, 3'b000, 0, 0, 3'b000, 0);
        step(); step();
`ifdef CV32E40P_FT_MON_LEAK_EN
        chk("leak.cnt_mid", 32'(err_cnt_o[2]), 32'd1);
`else
        chk("leak.cnt_mid", 32'(err_cnt_o[2]), 32'd2);
`endif
        for (int i = 0; i < 6; i++) step();
`ifdef CV32E40P_FT_MON_LEAK_EN
        chk("leak.cnt_end", 32'(err_cnt_o[2]), 32'd0);
        chk("leak.state",   32'(state_o[2]),   32'd0);
`else
        chk("leak.cnt_end", 32'(err_cnt_o[2]), 32'd2);
        chk("leak.state",   32'(state_o[2]),   32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
